// File: rtl/hamming_secded_serdes.sv
// SECDED Hamming codec with a serial front end.
// One controller runs either an encode frame or a decode frame.
module hamming_secded_serdes #(
  parameter int DATA_W    = 11,
  parameter int P_W       = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [DATA_W-1:0]    enc_data,
  input  logic                 enc_valid,
  output logic                 enc_ready,
  output logic                 ser_out,
  output logic                 ser_out_valid,
  output logic                 ser_out_first,
  input  logic                 ser_in,
  input  logic                 ser_in_valid,
  input  logic                 ser_in_first,
  output logic [DATA_W-1:0]    dec_data,
  output logic                 dec_valid,
  output logic                 dec_err_corr,
  output logic                 dec_err_uncorr,
  output logic [P_W-1:0]       dec_err_pos,
  output logic [ERR_CNT_W-1:0] corr_count,
  output logic [ERR_CNT_W-1:0] uncorr_count,
  input  logic                 cnt_clear,
  output logic                 busy
);

  localparam int CODE_W = DATA_W + P_W + 1;
  localparam int CNT_W  = $clog2(CODE_W + 1);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CODE_W - 1);
  localparam logic [P_W-1:0]   MAXPOS = P_W'(CODE_W - 1);

  if ((2 ** P_W) < CODE_W) begin : g_bad_params
    $error("P_W too small: 2**P_W must be >= DATA_W+P_W+1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC_SHIFT,
    S_DEC_SHIFT,
    S_DEC_EVAL
  } state_t;

  // Bit k of a codeword vector is Hamming position k; bit 0 is P0.
  function automatic logic [CODE_W-1:0] f_encode(
    input logic [DATA_W-1:0] d
  );
    logic [CODE_W-1:0] c;
    logic              par;
    int                k;
    c = '0;
    k = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int j = 0; j < P_W; j++) begin
      if ((1 << j) < CODE_W) begin
        par = 1'b0;
        for (int i = 1; i < CODE_W; i++) begin
          if ((((i >> j) & 1) == 1) && (i != (1 << j))) begin
            par = par ^ c[i];
          end
        end
        c[1 << j] = par;
      end
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(
    input logic [CODE_W-1:0] c
  );
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [P_W-1:0] f_syn(
    input logic [CODE_W-1:0] c
  );
    logic [P_W-1:0] s;
    s = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (c[i]) begin
        s = s ^ P_W'(i);
      end
    end
    return s;
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_shift;
  logic [CODE_W-1:0] r_rx;

  logic [DATA_W-1:0]    r_dec_data;
  logic                 r_dec_valid;
  logic                 r_dec_corr;
  logic                 r_dec_uncorr;
  logic [P_W-1:0]       r_dec_pos;
  logic [ERR_CNT_W-1:0] r_corr_cnt;
  logic [ERR_CNT_W-1:0] r_uncorr_cnt;

  logic              w_enc_ready;
  logic              w_enc_go;
  logic              w_dec_go;
  logic [CODE_W-1:0] w_enc_code;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] w_fix;
  logic [P_W-1:0]    w_syn;
  logic              w_par;
  logic              w_clean;
  logic              w_p0err;
  logic              w_single;
  logic              w_badpos;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_cor;

  assign w_enc_ready = (r_state == S_IDLE) && !mode;
  assign w_enc_go    = w_enc_ready && enc_valid;
  assign w_dec_go    = (r_state == S_IDLE) && mode &&
                       ser_in_valid && ser_in_first;
  assign w_enc_code  = f_encode(enc_data);

  // Receive shifter holds pos1 at bit 0 ... P0 at the top.
  assign w_code   = {r_rx[CODE_W-2:0], r_rx[CODE_W-1]};
  assign w_syn    = f_syn(w_code);
  assign w_par    = ^w_code;
  assign w_fix    = w_code ^ (CODE_W'(1) << w_syn);
  assign w_raw    = f_extract(w_code);
  assign w_cor    = f_extract(w_fix);
  assign w_clean  = (w_syn == '0) && !w_par;
  assign w_p0err  = (w_syn == '0) && w_par;
  assign w_single = (w_syn != '0) && w_par && (w_syn <= MAXPOS);
  assign w_badpos = (w_syn != '0) && w_par && (w_syn > MAXPOS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_enc_go)      w_next = S_ENC_SHIFT;
        else if (w_dec_go) w_next = S_DEC_SHIFT;
      end
      S_ENC_SHIFT: begin
        if (r_cnt == LAST) w_next = S_IDLE;
      end
      S_DEC_SHIFT: begin
        if (ser_in_valid && !ser_in_first &&
            (r_cnt == LAST)) begin
          w_next = S_DEC_EVAL;
        end
      end
      S_DEC_EVAL: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Bit counter plus transmit and receive shifters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_rx    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_enc_go) begin
            r_shift <= {w_enc_code[0],
                        w_enc_code[CODE_W-1:1]};
          end else if (w_dec_go) begin
            r_rx  <= {ser_in, (CODE_W-1)'(0)};
            r_cnt <= CNT_W'(1);
          end
        end
        S_ENC_SHIFT: begin
          r_shift <= r_shift >> 1;
          r_cnt   <= r_cnt + 1'b1;
        end
        S_DEC_SHIFT: begin
          if (ser_in_valid) begin
            if (ser_in_first) begin
              r_rx  <= {ser_in, (CODE_W-1)'(0)};
              r_cnt <= CNT_W'(1);
            end else begin
              r_rx  <= {ser_in, r_rx[CODE_W-1:1]};
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Syndrome evaluation registers the decoded word and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_data   <= '0;
      r_dec_valid  <= 1'b0;
      r_dec_corr   <= 1'b0;
      r_dec_uncorr <= 1'b0;
      r_dec_pos    <= '0;
    end else begin
      r_dec_valid <= 1'b0;
      if (r_state == S_DEC_EVAL) begin
        r_dec_valid <= 1'b1;
        unique case (1'b1)
          w_clean: begin
            r_dec_data   <= w_raw;
            r_dec_corr   <= 1'b0;
            r_dec_uncorr <= 1'b0;
            r_dec_pos    <= '0;
          end
          w_p0err: begin
            r_dec_data   <= w_raw;
            r_dec_corr   <= 1'b1;
            r_dec_uncorr <= 1'b0;
            r_dec_pos    <= '0;
          end
          w_single: begin
            r_dec_data   <= w_cor;
            r_dec_corr   <= 1'b1;
            r_dec_uncorr <= 1'b0;
            r_dec_pos    <= w_syn;
          end
          w_badpos: begin
            r_dec_data   <= w_raw;
            r_dec_corr   <= 1'b0;
            r_dec_uncorr <= 1'b1;
            r_dec_pos    <= '0;
          end
          default: begin
            r_dec_data   <= w_raw;
            r_dec_corr   <= 1'b0;
            r_dec_uncorr <= 1'b1;
            r_dec_pos    <= '0;
          end
        endcase
      end
    end
  end

  // Saturating link-quality counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (r_dec_valid) begin
      if (r_dec_corr && (r_corr_cnt != '1)) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (r_dec_uncorr && (r_uncorr_cnt != '1)) begin
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
      end
    end
  end

  assign enc_ready      = w_enc_ready;
  assign ser_out_valid  = (r_state == S_ENC_SHIFT);
  assign ser_out        = ser_out_valid & r_shift[0];
  assign ser_out_first  = ser_out_valid && (r_cnt == '0);
  assign dec_data       = r_dec_data;
  assign dec_valid      = r_dec_valid;
  assign dec_err_corr   = r_dec_corr;
  assign dec_err_uncorr = r_dec_uncorr;
  assign dec_err_pos    = r_dec_pos;
  assign corr_count     = r_corr_cnt;
  assign uncorr_count   = r_uncorr_cnt;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_hamming_secded_serdes.sv
// Directed bench for the SECDED serial codec.
// Expected codewords are hand-computed for DATA_W=11, P_W=4.
module tb_hamming_secded_serdes;

  localparam int DW = 11;
  localparam int PW = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] enc_data = '0;
  logic          enc_valid = 1'b0;
  logic          enc_ready;
  logic          ser_out;
  logic          ser_out_valid;
  logic          ser_out_first;
  logic          ser_in = 1'b0;
  logic          ser_in_valid = 1'b0;
  logic          ser_in_first = 1'b0;
  logic [DW-1:0] dec_data;
  logic          dec_valid;
  logic          dec_err_corr;
  logic          dec_err_uncorr;
  logic [PW-1:0] dec_err_pos;
  logic [EW-1:0] corr_count;
  logic [EW-1:0] uncorr_count;
  logic          cnt_clear = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Position-indexed codewords: bit k = position k, bit 0 = P0.
  // 11'h001 -> positions 0,1,2,3 set.
  // 11'h002 -> positions 0,1,4,5 set.
  logic [15:0] cw1;
  logic [15:0] cw2;

  hamming_secded_serdes #(
    .DATA_W(DW), .P_W(PW), .ERR_CNT_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .enc_data(enc_data), .enc_valid(enc_valid),
    .enc_ready(enc_ready),
    .ser_out(ser_out), .ser_out_valid(ser_out_valid),
    .ser_out_first(ser_out_first),
    .ser_in(ser_in), .ser_in_valid(ser_in_valid),
    .ser_in_first(ser_in_first),
    .dec_data(dec_data), .dec_valid(dec_valid),
    .dec_err_corr(dec_err_corr),
    .dec_err_uncorr(dec_err_uncorr),
    .dec_err_pos(dec_err_pos),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .cnt_clear(cnt_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame in wire order.
  task automatic send(input logic [15:0] cw,
                      input bit gaps,
                      input int nbits);
    for (int k = 1; k <= nbits; k++) begin
      ser_in       = (k == 16) ? cw[0] : cw[k];
      ser_in_valid = 1'b1;
      ser_in_first = (k == 1);
      tick();
      ser_in_valid = 1'b0;
      ser_in_first = 1'b0;
      if (gaps && k < 16 && (k % 3) == 0) begin
        ser_in = 1'b1;
        tick();
      end
    end
  endtask

  // Called one cycle after the last bit; leaves us on dec_valid.
  task automatic wait_dec(input string tag);
    chk({tag, "_dv_early"}, 32'(dec_valid), 32'd0);
    tick();
    chk({tag, "_dv"}, 32'(dec_valid), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    cw1 = 16'h000F;
    cw2 = 16'h0033;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_sov", 32'(ser_out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dv", 32'(dec_valid), 32'd0);
    chk("rst_data", 32'(dec_data), 32'd0);
    chk("rst_cc", 32'(corr_count), 32'd0);
    chk("rst_uc", 32'(uncorr_count), 32'd0);
    chk("rst_rdy", 32'(enc_ready), 32'd1);

    // Encode 11'h001: 1,1,1, twelve 0s, 1
    enc_data  = 11'h001;
    enc_valid = 1'b1;
    tick();
    enc_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("enc_sov", 32'(ser_out_valid), 32'd1);
      chk("enc_bit", 32'(ser_out),
          32'((k <= 3) || (k == 16)));
      chk("enc_first", 32'(ser_out_first), 32'(k == 1));
      chk("enc_rdy_lo", 32'(enc_ready), 32'd0);
      tick();
    end
    chk("enc_rdy_hi", 32'(enc_ready), 32'd1);
    chk("enc_sov_end", 32'(ser_out_valid), 32'd0);
    chk("enc_so_end", 32'(ser_out), 32'd0);

    // Clean decode with gaps; stray bit without first ignored
    mode = 1'b1;
    ser_in = 1'b1;
    ser_in_valid = 1'b1;
    tick();
    ser_in_valid = 1'b0;
    chk("stray_idle", 32'(busy), 32'd0);
    send(cw1, 1'b1, 16);
    wait_dec("clean");
    chk("clean_data", 32'(dec_data), 32'h001);
    chk("clean_corr", 32'(dec_err_corr), 32'd0);
    chk("clean_unc", 32'(dec_err_uncorr), 32'd0);
    tick();
    chk("clean_dv_off", 32'(dec_valid), 32'd0);
    chk("clean_hold", 32'(dec_data), 32'h001);
    chk("clean_cc", 32'(corr_count), 32'd0);
    chk("clean_uc", 32'(uncorr_count), 32'd0);

    // Position 5 flipped
    send(cw1 ^ 16'h0020, 1'b1, 16);
    wait_dec("p5");
    chk("p5_data", 32'(dec_data), 32'h001);
    chk("p5_corr", 32'(dec_err_corr), 32'd1);
    chk("p5_unc", 32'(dec_err_uncorr), 32'd0);
    chk("p5_pos", 32'(dec_err_pos), 32'd5);
    tick();
    chk("p5_cc", 32'(corr_count), 32'd1);

    // Only P0 flipped
    send(cw1 ^ 16'h0001, 1'b0, 16);
    wait_dec("p0");
    chk("p0_data", 32'(dec_data), 32'h001);
    chk("p0_corr", 32'(dec_err_corr), 32'd1);
    chk("p0_pos", 32'(dec_err_pos), 32'd0);
    tick();
    chk("p0_cc", 32'(corr_count), 32'd2);

    // Positions 3 and 5 flipped: double error, raw data
    send(cw1 ^ 16'h0028, 1'b0, 16);
    wait_dec("dbl");
    chk("dbl_data", 32'(dec_data), 32'h002);
    chk("dbl_corr", 32'(dec_err_corr), 32'd0);
    chk("dbl_unc", 32'(dec_err_uncorr), 32'd1);
    chk("dbl_pos", 32'(dec_err_pos), 32'd0);
    tick();
    chk("dbl_uc", 32'(uncorr_count), 32'd1);
    chk("dbl_cc", 32'(corr_count), 32'd2);

    // Clear, then saturate the 2-bit corrected counter
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clr_cc", 32'(corr_count), 32'd0);
    chk("clr_uc", 32'(uncorr_count), 32'd0);
    for (int f = 0; f < 5; f++) begin
      send(cw1 ^ 16'h0080, 1'b0, 16);
      wait_dec("sat");
      chk("sat_data", 32'(dec_data), 32'h001);
      chk("sat_pos", 32'(dec_err_pos), 32'd7);
      tick();
    end
    chk("sat_cc", 32'(corr_count), 32'd3);

    // cnt_clear coincident with dec_valid wins
    send(cw1 ^ 16'h0200, 1'b0, 16);
    wait_dec("cc_clr");
    chk("cc_clr_pos", 32'(dec_err_pos), 32'd9);
    chk("cc_clr_data", 32'(dec_data), 32'h001);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("cc_clr_cc", 32'(corr_count), 32'd0);
    tick();
    chk("cc_clr_cc2", 32'(corr_count), 32'd0);

    // Resync: first re-asserted at bit 7 starts a new frame
    send(cw1, 1'b0, 6);
    send(cw2, 1'b0, 16);
    wait_dec("resync");
    chk("resync_data", 32'(dec_data), 32'h002);
    chk("resync_corr", 32'(dec_err_corr), 32'd0);
    chk("resync_unc", 32'(dec_err_uncorr), 32'd0);
    tick();

    // Reset during an encode frame
    mode      = 1'b0;
    enc_data  = 11'h7FF;
    enc_valid = 1'b1;
    tick();
    enc_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_sov", 32'(ser_out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstm_sov", 32'(ser_out_valid), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_data", 32'(dec_data), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("rstm_dv", 32'(dec_valid), 32'd0);
      chk("rstm_sov2", 32'(ser_out_valid), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
